// File: rtl/minmax_scan_unit.sv
// minmax_scan_unit: scans a block of signed samples and holds its min/max
// and their first-occurrence indices until the consumer acknowledges.
module minmax_scan_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             energy,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx
);
    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t state, state_nx;
    logic [CNT_W:0] cnt, len_r;
    logic [WIDTH:0] d_min, d_max;
    logic accept, last, less, greater;

    assign in_ready  = energy && state == SCAN;
    assign busy      = state == SCAN;
    assign res_valid = state == HOLD;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == len_r - (CNT_W+1)'(1);
    // Sign-extended subtract: the extra bit makes the sign exact even where
    // a WIDTH-bit difference would overflow.
    assign d_min     = {in_data[WIDTH-1], in_data} - {out_min[WIDTH-1], out_min};
    assign d_max     = {out_max[WIDTH-1], out_max} - {in_data[WIDTH-1], in_data};
    assign less      = d_min[WIDTH];
    assign greater   = d_max[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (energy) begin
            case (state)
                IDLE:    state_nx = start ? SCAN : IDLE;
                SCAN:    state_nx = (accept && last) ? HOLD : SCAN;
                HOLD:    state_nx = res_ack ? IDLE : HOLD;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            len_r       <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_min_idx <= '0;
            out_max_idx <= '0;
        end else if (energy) begin
            if (state == IDLE && start) begin
                cnt   <= '0;
                len_r <= (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
            end
            if (accept) begin
                cnt <= cnt + (CNT_W+1)'(1);
                if (cnt == '0 || less) begin
                    out_min     <= in_data;
                    out_min_idx <= cnt[CNT_W-1:0];
                end
                if (cnt == '0 || greater) begin
                    out_max     <= in_data;
                    out_max_idx <= cnt[CNT_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_minmax_scan_unit.sv
// tb_minmax_scan_unit: directed and randomized block scans checked against
// a plain integer min/max reference.
module tb_minmax_scan_unit;
    logic        clk = 0, rst_n = 0, energy = 1, start = 0, in_valid = 0, res_ack = 0;
    logic [7:0]  len = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, busy, res_valid;
    logic [15:0] out_min, out_max;
    logic [7:0]  out_min_idx, out_max_idx;
    int total = 0, bad = 0;

    minmax_scan_unit dut (
        .clk(clk), .rst_n(rst_n), .energy(energy), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
        .res_valid(res_valid), .res_ack(res_ack), .out_min(out_min), .out_max(out_max),
        .out_min_idx(out_min_idx), .out_max_idx(out_max_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] l);
        @(negedge clk);
        start = 1;
        len = l;
        @(negedge clk);
        start = 0;
    endtask

    // Feeds all of s with random in_valid gaps; at index frz holds energy low for 3 cycles.
    task automatic feed(input logic [15:0] s[$], input int gap, input int frz, output int acc);
        int i = 0, guard = 0;
        logic [15:0] mn, mx;
        acc = 0;
        while (i < s.size() && guard < 20000) begin
            guard++;
            if (i == frz) begin
                frz = -1;
                energy = 0;
                in_valid = 1;
                in_data = s[i];
                mn = out_min;
                mx = out_max;
                repeat (3) begin
                    #1 chk("frz_ready", in_ready, 0);
                    @(negedge clk);
                    chk("frz_min", out_min, mn);
                    chk("frz_max", out_max, mx);
                    chk("frz_busy", busy, 1);
                end
                energy = 1;
            end
            in_valid = ($urandom_range(99) >= gap);
            in_data = s[i];
            #1;
            if (in_valid && in_ready) begin
                i++;
                acc++;
            end
            @(negedge clk);
        end
        in_valid = 0;
        if (guard >= 20000) chk("feed_timeout", 0, 1);
    endtask

    task automatic check_res(input string tag, input logic [15:0] s[$]);
        int mn = 0, mx = 0, mni = 0, mxi = 0, v;
        logic [15:0] hold_min;
        foreach (s[i]) begin
            v = int'($signed(s[i]));
            if (i == 0 || v < mn) begin mn = v; mni = i; end
            if (i == 0 || v > mx) begin mx = v; mxi = i; end
        end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_min"}, out_min, 32'(mn[15:0]));
        chk({tag, "_max"}, out_max, 32'(mx[15:0]));
        chk({tag, "_min_idx"}, out_min_idx, 32'(mni[7:0]));
        chk({tag, "_max_idx"}, out_max_idx, 32'(mxi[7:0]));
        @(negedge clk);
        chk({tag, "_stable"}, res_valid, 1);
        hold_min = out_min;
        res_ack = 1;
        @(negedge clk);
        res_ack = 0;
        chk({tag, "_acked"}, res_valid, 0);
        chk({tag, "_retain"}, out_min, hold_min);
    endtask

    initial begin
        logic [15:0] q[$];
        int acc;
        #3;
        chk("rst_min", out_min, 0);
        chk("rst_max", out_max, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1;

        // Block of 4 with a tie on the minimum
        q = '{16'd5, 16'hFFFD, 16'd12, 16'hFFFD};
        do_start(8'd4);
        chk("t1_busy", busy, 1);
        feed(q, 0, -1, acc);
        chk("t1_acc", acc, 4);
        chk("t1_min_c", out_min, 16'hFFFD);
        chk("t1_minidx_c", out_min_idx, 1);
        chk("t1_max_c", out_max, 12);
        chk("t1_maxidx_c", out_max_idx, 2);
        check_res("t1", q);

        // Extreme values whose naive difference overflows
        q = '{16'h7FFF, 16'h8000};
        do_start(8'd2);
        feed(q, 0, -1, acc);
        chk("t2_min_c", out_min, 16'h8000);
        chk("t2_minidx_c", out_min_idx, 1);
        chk("t2_max_c", out_max, 16'h7FFF);
        check_res("t2", q);

        // len=0 means 256 samples, fed with random gaps
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(16'(i));
        do_start(8'd0);
        feed(q, 30, -1, acc);
        chk("t3_acc", acc, 256);
        chk("t3_maxidx_c", out_max_idx, 255);
        check_res("t3", q);

        // Freeze mid-scan
        q = '{16'd100, 16'hFF00, 16'd7, 16'd300, 16'hFF00, 16'd300};
        do_start(8'd6);
        feed(q, 0, 3, acc);
        chk("t4_acc", acc, 6);
        check_res("t4", q);

        // Random blocks, small value range to provoke ties
        for (int b = 0; b < 6; b++) begin
            int n = $urandom_range(1, 40);
            q = {};
            for (int i = 0; i < n; i++)
                q.push_back(b[0] ? 16'($urandom) : 16'($signed($urandom_range(0, 8)) - 4));
            do_start(8'(n));
            feed(q, 25, (b == 2) ? n / 2 : -1, acc);
            chk("rnd_acc", acc, n);
            check_res("rnd", q);
        end

        // Async reset in the middle of a block
        q = '{16'd9, 16'd3, 16'd4};
        do_start(8'd10);
        feed(q, 0, -1, acc);
        #2 rst_n = 0;
        #1;
        chk("t5_min0", out_min, 0);
        chk("t5_max0", out_max, 0);
        chk("t5_idx0", out_max_idx, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_ready0", in_ready, 0);
        @(negedge clk);
        rst_n = 1;
        q = '{16'hFFF9};
        do_start(8'd1);
        feed(q, 0, -1, acc);
        chk("t5_min_c", out_min, 16'hFFF9);
        chk("t5_max_c", out_max, 16'hFFF9);

        // start together with res_ack in HOLD must not begin a scan
        chk("t6_hold", res_valid, 1);
        start = 1;
        res_ack = 1;
        @(negedge clk);
        start = 0;
        res_ack = 0;
        chk("t6_idle_valid", res_valid, 0);
        chk("t6_idle_busy", busy, 0);
        @(negedge clk);
        chk("t6_no_scan", busy, 0);
        q = '{16'd42, 16'd41};
        do_start(8'd2);
        chk("t6_scan", busy, 1);
        feed(q, 0, -1, acc);
        check_res("t6", q);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
